// File: rtl/anton_neopixel_receiver.sv
// anton_neopixel_receiver: WS2812 line decoder writing one byte per strobe into a pixel buffer.
// Define ANTON_NEOPIXEL_RX_GLITCH_FILTER_EN to add a 3-sample majority spike filter (+1 clk latency).
`timescale 1ns/1ps
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 63
`endif
`ifndef RESET_DELAY_DEFAULT
`define RESET_DELAY_DEFAULT 385
`endif
module anton_neopixel_receiver #(
   parameter int BUFFER_END    = `BUFFER_END_DEFAULT,
   parameter int RESET_DELAY   = `RESET_DELAY_DEFAULT,
   parameter int BIT_THRESHOLD = 4,
   parameter int MAX_HIGH      = 10,
   localparam int BUFFER_BITS  = BUFFER_END > 0 ? $clog2(BUFFER_END + 1) : 1
) (
   input  logic                   clk7mhz,
   input  logic                   reset,
   input  logic                   neoDataIn,
   input  logic                   clrStatus,
   output logic [BUFFER_BITS-1:0] wrAddr,
   output logic [7:0]             wrData,
   output logic                   wrValid,
   output logic                   frameDone,
   output logic [BUFFER_BITS:0]   frameLen,
   output logic                   rxError,
   output logic                   rxOverflow,
   output logic                   rxPartial,
   output logic [1:0]             rxState
);
   typedef enum logic [1:0] {SYNC = 2'd0, IDLE = 2'd1, HIGH = 2'd2, LOW = 2'd3} state_t;
   localparam int CMAX = RESET_DELAY > MAX_HIGH + 1 ? RESET_DELAY : MAX_HIGH + 1;
   localparam int CW = $clog2(CMAX + 1);
   localparam logic [CW-1:0] RD = CW'(RESET_DELAY);
   localparam logic [CW-1:0] MH = CW'(MAX_HIGH);
   localparam logic [CW-1:0] BT = CW'(BIT_THRESHOLD);
   localparam logic [BUFFER_BITS:0] LAST = (BUFFER_BITS + 1)'(BUFFER_END);
   state_t state, state_n;
   logic [1:0] sync;
   logic s, s_d, rise, fall;
   logic [CW-1:0] cnt, cnt_n, cnt_inc;
   logic [2:0] bits, bits_n;
   logic [7:0] shreg, shreg_n;
   logic [BUFFER_BITS:0] idx, idx_n;
   logic rdy, rdy_n, valid_n, done_n, err_ev, ovf_ev, part_ev;
   always_ff @(posedge clk7mhz) begin
      sync <= reset ? 2'b00 : {sync[0], neoDataIn};
      s_d <= reset ? 1'b0 : s;
   end
`ifdef ANTON_NEOPIXEL_RX_GLITCH_FILTER_EN
   logic [1:0] hist;
   always_ff @(posedge clk7mhz) hist <= reset ? 2'b00 : {hist[0], sync[1]};
   assign s = (sync[1] & hist[0]) | (sync[1] & hist[1]) | (hist[0] & hist[1]);
`else
   assign s = sync[1];
`endif
   assign rise = s & ~s_d;
   assign fall = ~s & s_d;
   assign cnt_inc = cnt + CW'(1);
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      bits_n = bits;
      shreg_n = shreg;
      idx_n = idx;
      rdy_n = 1'b0;
      valid_n = 1'b0;
      done_n = 1'b0;
      err_ev = 1'b0;
      ovf_ev = 1'b0;
      part_ev = 1'b0;
      // a byte completed on the previous tick is committed (or dropped) one clock later
      if (rdy) begin
         ovf_ev = idx > LAST;
         valid_n = ~ovf_ev;
         idx_n = ovf_ev ? idx : idx + 1'b1;
      end
      case (state)
         SYNC: begin
            cnt_n = s ? '0 : cnt_inc;
            state_n = (!s && cnt_inc == RD) ? IDLE : SYNC;
         end
         IDLE: if (rise) begin
            state_n = HIGH;
            cnt_n = CW'(1);
            idx_n = '0;
            bits_n = '0;
         end
         HIGH: if (fall) begin
            shreg_n = {shreg[6:0], cnt >= BT};
            bits_n = bits + 3'd1;
            rdy_n = &bits;
            state_n = LOW;
            cnt_n = CW'(1);
         end else if (cnt_inc > MH) begin
            err_ev = 1'b1;
            state_n = SYNC;
            cnt_n = '0;
         end else cnt_n = cnt_inc;
         default: if (rise) begin
            state_n = HIGH;
            cnt_n = CW'(1);
         end else if (cnt_inc == RD) begin
            state_n = IDLE;
            done_n = 1'b1;
            part_ev = bits != 3'd0;
         end else cnt_n = cnt_inc;
      endcase
   end
   always_ff @(posedge clk7mhz) begin
      if (reset) begin
         state <= SYNC;
         cnt <= '0;
         bits <= '0;
         shreg <= '0;
         idx <= '0;
         rdy <= 1'b0;
         wrAddr <= '0;
         wrData <= '0;
         wrValid <= 1'b0;
         frameDone <= 1'b0;
         frameLen <= '0;
         rxError <= 1'b0;
         rxOverflow <= 1'b0;
         rxPartial <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         bits <= bits_n;
         shreg <= shreg_n;
         idx <= idx_n;
         rdy <= rdy_n;
         wrValid <= valid_n;
         wrAddr <= valid_n ? idx[BUFFER_BITS-1:0] : wrAddr;
         wrData <= valid_n ? shreg : wrData;
         frameDone <= done_n;
         frameLen <= done_n ? idx : frameLen;
         rxError <= err_ev | (rxError & ~clrStatus);
         rxOverflow <= ovf_ev | (rxOverflow & ~clrStatus);
         rxPartial <= part_ev | (rxPartial & ~clrStatus);
      end
   end
   assign rxState = state;
endmodule

// File: tb/tb_anton_neopixel_receiver.sv
// tb_anton_neopixel_receiver: random and directed NeoPixel frames checked against a pulse-level decode model.
`timescale 1ns/1ps
module tb_anton_neopixel_receiver;
   localparam int BE = 3;
   localparam int RD = 385;
`ifdef ANTON_NEOPIXEL_RX_GLITCH_FILTER_EN
   localparam int FILT = 1;
`else
   localparam int FILT = 0;
`endif
   logic clk7mhz = 1'b0, reset = 1'b1, neoDataIn = 1'b0, clrStatus = 1'b0;
   logic [1:0] wrAddr;
   logic [7:0] wrData;
   logic wrValid, frameDone;
   logic [2:0] frameLen;
   logic rxError, rxOverflow, rxPartial;
   logic [1:0] rxState;
   int n_vec = 0, n_err = 0, cyc = 0, done_cnt = 0, last_len = 0, c;
   int wr_data_q[$], wr_addr_q[$], wr_cyc_q[$];
   int hi_q[$], lo_q[$], fall_cyc[$];

   anton_neopixel_receiver #(.BUFFER_END(BE), .RESET_DELAY(RD)) dut (
      .clk7mhz(clk7mhz), .reset(reset), .neoDataIn(neoDataIn), .clrStatus(clrStatus),
      .wrAddr(wrAddr), .wrData(wrData), .wrValid(wrValid), .frameDone(frameDone),
      .frameLen(frameLen), .rxError(rxError), .rxOverflow(rxOverflow), .rxPartial(rxPartial),
      .rxState(rxState));

   always #71 clk7mhz = ~clk7mhz;
   always @(posedge clk7mhz) cyc <= cyc + 1;
   always @(negedge clk7mhz) begin
      if (wrValid) begin
         wr_data_q.push_back(int'(wrData));
         wr_addr_q.push_back(int'(wrAddr));
         wr_cyc_q.push_back(cyc);
      end
      if (frameDone) begin
         done_cnt++;
         last_len = int'(frameLen);
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // holds the line at v for n clocks; t is the cycle count when the level was applied
   task automatic drive(input logic v, input int n, output int t);
      @(negedge clk7mhz);
      neoDataIn = v;
      t = cyc;
      repeat (n - 1) @(negedge clk7mhz);
   endtask

   task automatic add_byte(input int v);
      for (int j = 7; j >= 0; j--) begin
         hi_q.push_back(v[j] ? 5 : 3);
         lo_q.push_back(v[j] ? 3 : 5);
      end
   endtask

   task automatic clear_mon();
      wr_data_q.delete();
      wr_addr_q.delete();
      wr_cyc_q.delete();
      done_cnt = 0;
   endtask

   task automatic run_frame(input string tag, input int exp_err);
      int bits[$], src[$];
      int nb, nbytes, nw, b, t;
      clear_mon();
      fall_cyc.delete();
      foreach (hi_q[i]) begin
         drive(1'b1, hi_q[i], t);
         drive(1'b0, lo_q[i], t);
         fall_cyc.push_back(t);
      end
      drive(1'b0, RD + 20, t);
      foreach (hi_q[i])
         if (!(FILT == 1 && hi_q[i] == 1)) begin
            bits.push_back(hi_q[i] >= 4 ? 1 : 0);
            src.push_back(i);
         end
      nb = bits.size();
      nbytes = nb / 8;
      nw = nbytes > BE + 1 ? BE + 1 : nbytes;
      chk({tag, " writes"}, wr_data_q.size(), nw);
      for (int k = 0; k < nw && k < wr_data_q.size(); k++) begin
         b = 0;
         for (int j = 0; j < 8; j++) b = b * 2 + bits[8 * k + j];
         chk({tag, " data"}, wr_data_q[k], b);
         chk({tag, " addr"}, wr_addr_q[k], k);
         chk({tag, " latency"}, wr_cyc_q[k] - fall_cyc[src[8 * k + 7]], 4 + FILT);
      end
      chk({tag, " frameDone"}, done_cnt, 1);
      chk({tag, " frameLen"}, last_len, nw);
      chk({tag, " partial"}, int'(rxPartial), nb % 8 != 0 ? 1 : 0);
      chk({tag, " overflow"}, int'(rxOverflow), nbytes > BE + 1 ? 1 : 0);
      chk({tag, " error"}, int'(rxError), exp_err);
      @(negedge clk7mhz) clrStatus = 1'b1;
      @(negedge clk7mhz) clrStatus = 1'b0;
      chk({tag, " flags cleared"}, int'({rxError, rxOverflow, rxPartial}), 0);
      hi_q.delete();
      lo_q.delete();
   endtask

   initial begin
      neoDataIn = 1'b1;
      repeat (3) @(negedge clk7mhz);
      chk("rst wrValid", int'(wrValid), 0);
      chk("rst frameDone", int'(frameDone), 0);
      chk("rst frameLen", int'(frameLen), 0);
      chk("rst wrAddr", int'(wrAddr), 0);
      chk("rst wrData", int'(wrData), 0);
      chk("rst flags", int'({rxError, rxOverflow, rxPartial}), 0);
      chk("rst state", int'(rxState), 0);
      reset = 1'b0;
      clear_mon();
      repeat (100) @(negedge clk7mhz);
      chk("t2 high state", int'(rxState), 0);
      drive(1'b0, 384, c);
      chk("t2 state 384", int'(rxState), 0);
      repeat (10) @(negedge clk7mhz);
      chk("t2 state idle", int'(rxState), 1);
      chk("t2 no writes", wr_data_q.size(), 0);
      chk("t2 no done", done_cnt, 0);

      add_byte(8'hA5);
      add_byte(8'h3C);
      run_frame("t1", 0);

      clear_mon();
      drive(1'b1, 5, c);
      drive(1'b0, 3, c);
      drive(1'b1, 3, c);
      drive(1'b0, 5, c);
      @(negedge clk7mhz) neoDataIn = 1'b1;
      for (int i = 1; i <= 13 + FILT; i++) begin
         @(negedge clk7mhz);
         if (i == 12) neoDataIn = 1'b0;
         if (i == 12 + FILT) chk("t3 err early", int'(rxError), 0);
      end
      chk("t3 err", int'(rxError), 1);
      chk("t3 state", int'(rxState), 0);
      drive(1'b0, RD + 20, c);
      chk("t3 no done", done_cnt, 0);
      chk("t3 no writes", wr_data_q.size(), 0);
      add_byte(8'h01);
      run_frame("t3b", 1);

      add_byte(8'hFF);
      for (int j = 0; j < 4; j++) begin
         hi_q.push_back(6);
         lo_q.push_back(3);
      end
      run_frame("t4", 0);

      for (int k = 0; k < 6; k++) add_byte(int'($urandom_range(0, 255)));
      run_frame("t5", 0);

      add_byte(8'hA5);
      lo_q[2] = 2;
      hi_q.insert(3, 1);
      lo_q.insert(3, 3);
      run_frame("t6", 0);

      for (int f = 0; f < 15; f++) begin
         int nbits, bv;
         nbits = int'($urandom_range(1, 44));
         for (int j = 0; j < nbits; j++) begin
            if ($urandom_range(0, 7) == 0) begin
               hi_q.push_back(1);
               lo_q.push_back(int'($urandom_range(2, 20)));
            end
            bv = int'($urandom_range(0, 1));
            hi_q.push_back(bv == 1 ? int'($urandom_range(4, 10)) : int'($urandom_range(2, 3)));
            lo_q.push_back(int'($urandom_range(2, 40)));
         end
         run_frame("rnd", 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
